// File: rtl/booth_nucleo.sv
// Radix-2 Booth sequential signed multiplier: one iteration per clock, registered product and done strobe.
// Optional overlapping-start flag enabled by defining BOOTH_ERR_SOLAPE_EN.
module booth_nucleo #(
  parameter int ancho = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inicio,
  input  logic [ancho-1:0]     multiplicando,
  input  logic [ancho-1:0]     multiplicador,
  output logic [2*ancho-1:0]   producto,
  output logic                 listo,
`ifdef BOOTH_ERR_SOLAPE_EN
  output logic                 err_solape,
`endif
  output logic                 ocupado
);

  localparam int CW = $clog2(ancho + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } estado_t;

  estado_t              estado_q, estado_d;
  logic [ancho:0]       a_q, a_d;
  logic [ancho:0]       m_q, m_d;
  logic [ancho-1:0]     q_q, q_d;
  logic                 q1_q, q1_d;
  logic [CW-1:0]        cont_q, cont_d;
  logic [2*ancho-1:0]   producto_q, producto_d;
  logic                 listo_q, listo_d;
  logic                 ocupado_q, ocupado_d;
  logic [ancho:0]       suma_s;
`ifdef BOOTH_ERR_SOLAPE_EN
  logic                 err_q, err_d;
`endif

  // Next-state, Booth datapath and output computation
  always_comb begin
    estado_d   = estado_q;
    a_d        = a_q;
    m_d        = m_q;
    q_d        = q_q;
    q1_d       = q1_q;
    cont_d     = cont_q;
    producto_d = producto_q;
    listo_d    = 1'b0;
    ocupado_d  = ocupado_q;
    suma_s     = a_q;
`ifdef BOOTH_ERR_SOLAPE_EN
    err_d      = err_q | (inicio & (estado_q != IDLE));
`endif
    case (estado_q)
      IDLE: begin
        if (inicio) begin
          a_d       = {(ancho+1){1'b0}};
          q_d       = multiplicador;
          q1_d      = 1'b0;
          m_d       = {multiplicando[ancho-1], multiplicando};
          cont_d    = CW'(ancho);
          ocupado_d = 1'b1;
          estado_d  = CALC;
        end else begin
          estado_d  = IDLE;
        end
      end
      CALC: begin
        case ({q_q[0], q1_q})
          2'b01:   suma_s = a_q + m_q;
          2'b10:   suma_s = a_q - m_q;
          default: suma_s = a_q;
        endcase
        // Arithmetic right shift of {A', Q, q_1}
        a_d    = {suma_s[ancho], suma_s[ancho:1]};
        q_d    = {suma_s[0], q_q[ancho-1:1]};
        q1_d   = q_q[0];
        cont_d = cont_q - CW'(1'b1);
        if (cont_q == CW'(1'b1)) begin
          estado_d = FIN;
        end else begin
          estado_d = CALC;
        end
      end
      FIN: begin
        producto_d = {a_q[ancho-1:0], q_q};
        listo_d    = 1'b1;
        ocupado_d  = 1'b0;
        estado_d   = IDLE;
      end
      default: begin
        estado_d  = IDLE;
        ocupado_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q   <= IDLE;
      a_q        <= {(ancho+1){1'b0}};
      m_q        <= {(ancho+1){1'b0}};
      q_q        <= {ancho{1'b0}};
      q1_q       <= 1'b0;
      cont_q     <= {CW{1'b0}};
      producto_q <= {(2*ancho){1'b0}};
      listo_q    <= 1'b0;
      ocupado_q  <= 1'b0;
`ifdef BOOTH_ERR_SOLAPE_EN
      err_q      <= 1'b0;
`endif
    end else begin
      estado_q   <= estado_d;
      a_q        <= a_d;
      m_q        <= m_d;
      q_q        <= q_d;
      q1_q       <= q1_d;
      cont_q     <= cont_d;
      producto_q <= producto_d;
      listo_q    <= listo_d;
      ocupado_q  <= ocupado_d;
`ifdef BOOTH_ERR_SOLAPE_EN
      err_q      <= err_d;
`endif
    end
  end

  assign producto = producto_q;
  assign listo    = listo_q;
  assign ocupado  = ocupado_q;
`ifdef BOOTH_ERR_SOLAPE_EN
  assign err_solape = err_q;
`endif

endmodule

// File: tb/tb_booth_nucleo.sv
// Self-checking bench for booth_nucleo (ancho = 4): vector table plus multi-cycle corner sequences.
module tb_booth_nucleo;

  logic       clk;
  logic       rst;
  logic       inicio;
  logic [3:0] multiplicando;
  logic [3:0] multiplicador;
  logic [7:0] producto;
  logic       listo;
  logic       ocupado;
`ifdef BOOTH_ERR_SOLAPE_EN
  logic       err_solape;
`endif

  int tests;
  int fails;
  logic [7:0] sb_q[$];

  typedef struct {
    logic [3:0] m;
    logic [3:0] q;
    logic [7:0] p;
  } vec_t;

  vec_t tabla[7];

  booth_nucleo #(.ancho(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .inicio        (inicio),
    .multiplicando (multiplicando),
    .multiplicador (multiplicador),
    .producto      (producto),
    .listo         (listo),
`ifdef BOOTH_ERR_SOLAPE_EN
    .err_solape    (err_solape),
`endif
    .ocupado       (ocupado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [3:0] m, input logic [3:0] q, input logic [7:0] p);
    logic [7:0] prev;
    logic [7:0] e;
    int edges;
    int busy;
    logic seen;
    @(negedge clk);
    multiplicando = m;
    multiplicador = q;
    inicio = 1'b1;
    sb_q.push_back(p);
    prev = producto;
    @(negedge clk);
    inicio = 1'b0;
    multiplicando = ~m;
    multiplicador = ~q;
    busy = ocupado ? 1 : 0;
    edges = 0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      edges++;
      if (listo) begin
        seen = 1'b1;
      end else begin
        if (ocupado) busy++;
        check("producto_held", 16'(producto), 16'(prev));
      end
    end
    check("listo_seen", 16'(seen), 16'd1);
    if (seen) begin
      e = sb_q.pop_front();
      check("latency", 16'(edges), 16'd5);
      check("ocupado_cycles", 16'(busy), 16'd5);
      check("ocupado_at_done", 16'(ocupado), 16'd0);
      check("producto", 16'(producto), 16'(e));
      @(negedge clk);
      check("listo_width", 16'(listo), 16'd0);
    end else begin
      sb_q.delete();
    end
  endtask

  initial begin
    int n;
    int pulses;
    logic prev_l;
    logic [3:0] rm;
    logic [3:0] rq;
    int pm;

    tabla[0] = '{4'b1101, 4'b0011, 8'b11110111};
    tabla[1] = '{4'b1000, 4'b1000, 8'b01000000};
    tabla[2] = '{4'b0111, 4'b1000, 8'b11001000};
    tabla[3] = '{4'b0000, 4'b1011, 8'b00000000};
    tabla[4] = '{4'b0001, 4'b1011, 8'b11111011};
    tabla[5] = '{4'b0111, 4'b0111, 8'b00110001};
    tabla[6] = '{4'b0111, 4'b0001, 8'b00000111};

    tests = 0;
    fails = 0;
    rst = 1'b1;
    inicio = 1'b0;
    multiplicando = 4'b0000;
    multiplicador = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    check("rst_producto", 16'(producto), 16'd0);
    check("rst_listo", 16'(listo), 16'd0);
    check("rst_ocupado", 16'(ocupado), 16'd0);
`ifdef BOOTH_ERR_SOLAPE_EN
    check("rst_err_solape", 16'(err_solape), 16'd0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_op(tabla[i].m, tabla[i].q, tabla[i].p);
    end

    for (int i = 0; i < 4; i++) begin
      rm = 4'($urandom_range(0, 15));
      rq = 4'($urandom_range(0, 15));
      pm = $signed(rm) * $signed(rq);
      run_op(rm, rq, 8'(pm));
    end

    // Overlapping start at the second CALC edge is ignored
    @(negedge clk);
    multiplicando = 4'b0111;
    multiplicador = 4'b0111;
    inicio = 1'b1;
    sb_q.push_back(8'b00110001);
    @(negedge clk);
    inicio = 1'b0;
    @(negedge clk);
    multiplicando = 4'b0010;
    multiplicador = 4'b0010;
    inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (listo) begin
        pulses++;
        if (sb_q.size() > 0) check("overlap_producto", 16'(producto), 16'(sb_q.pop_front()));
      end
    end
    check("overlap_pulses", 16'(pulses), 16'd1);
`ifdef BOOTH_ERR_SOLAPE_EN
    check("err_solape_set", 16'(err_solape), 16'd1);
`endif

    // Back-to-back with inicio held high
    sb_q.delete();
    for (int i = 0; i < 3; i++) sb_q.push_back(8'b11110001);
    @(negedge clk);
    multiplicando = 4'b1101;
    multiplicador = 4'b0101;
    inicio = 1'b1;
    n = 0;
    prev_l = 1'b0;
    for (int k = 0; k < 60 && n < 3; k++) begin
      @(negedge clk);
      if (prev_l) check("b2b_listo_width", 16'(listo), 16'd0);
      prev_l = listo;
      if (listo) begin
        check("b2b_producto", 16'(producto), 16'(sb_q.pop_front()));
        n++;
        if (n == 3) inicio = 1'b0;
      end
    end
    check("b2b_count", 16'(n), 16'd3);
    @(negedge clk);
    check("b2b_listo_end", 16'(listo), 16'd0);
    check("b2b_idle", 16'(ocupado), 16'd0);
`ifdef BOOTH_ERR_SOLAPE_EN
    check("err_solape_sticky", 16'(err_solape), 16'd1);
`endif

    // Reset in the middle of CALC
    @(negedge clk);
    multiplicando = 4'b0011;
    multiplicador = 4'b0011;
    inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_producto", 16'(producto), 16'd0);
    check("midrst_listo", 16'(listo), 16'd0);
    check("midrst_ocupado", 16'(ocupado), 16'd0);
`ifdef BOOTH_ERR_SOLAPE_EN
    check("midrst_err_solape", 16'(err_solape), 16'd0);
`endif
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (listo) pulses++;
    end
    check("midrst_discarded", 16'(pulses), 16'd0);
    run_op(4'b0010, 4'b1100, 8'b11111000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
